// File: rtl/corr_pkg.sv
// Shared definitions for the correlator front end: signal spacing limits,
// data widths, default bin length and the saturating-arithmetic helpers.
package corr_pkg;

  localparam int MIN_SIG_SPACING = 32;
  localparam int MAX_BIN_CYCLES  = 65535;
  localparam int CORR_DATA_W     = 8;
  localparam int DEF_BIN_CYCLES  = 50;
  localparam int BIN_CNT_W       = 16;
  localparam int OVF_CNT_W       = 16;

  // Whether the bin timer is allowed to advance this cycle.
  typedef enum logic [0:0] {
    BIN_HELD    = 1'b0,
    BIN_RUNNING = 1'b1
  } bin_mode_e;

  // Saturating add, decision half: reports whether a + b would exceed maxVal.
  // The sum is formed one bit wider, so it cannot wrap for any 32-bit
  // operands and the caller can clamp to maxVal when this returns 1.
  function automatic logic satAddOver(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] maxVal);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum > {1'b0, maxVal};
  endfunction

  // Saturating increment for the 16-bit event counters; sticks at all-ones.
  function automatic logic [OVF_CNT_W-1:0] satInc(input logic [OVF_CNT_W-1:0] a);
    return (a == {OVF_CNT_W{1'b1}}) ? a : a + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Brings an asynchronous level into the clk domain through two flops and
// flags its rising edge with a third history flop. A rising edge first
// sampled at clk edge k shows up on o_rise during the cycle after edge k+1.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Synchronizer chain plus history flop; these keep running regardless of
  // any enable in the parent so the edge history is never stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/photon_binner.sv
// Photon binner: counts synchronized detector pulses into fixed bins of
// BIN_CYCLES clocks and emits each closed bin as a count plus a one-cycle
// strobe for the correlator. Define PHOTON_BINNER_OVF_CNT_EN to add the
// ovf_cnt port counting saturated bins.
// rst_n is an active-high synchronous reset despite its name.
module photon_binner
  import corr_pkg::*;
#(
  parameter int BIN_CYCLES = DEF_BIN_CYCLES,
  parameter int CNT_W      = CORR_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             photon,
  output logic [CNT_W-1:0] bin_data,
  output logic             bin_sig,
  output logic             bin_sat
`ifdef PHOTON_BINNER_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  localparam logic [BIN_CNT_W-1:0] BIN_LAST = BIN_CNT_W'(BIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]     ACC_MAX  = {CNT_W{1'b1}};

  // The correlator cannot take strobes closer than MIN_SIG_SPACING apart,
  // and the bin timer is only BIN_CNT_W bits wide.
  if (BIN_CYCLES < MIN_SIG_SPACING) begin : g_binTooShort
    $error("photon_binner: BIN_CYCLES below minimum strobe spacing");
  end
  if (BIN_CYCLES > MAX_BIN_CYCLES) begin : g_binTooLong
    $error("photon_binner: BIN_CYCLES exceeds bin timer range");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_badCntW
    $error("photon_binner: CNT_W must be 1..32");
  end

  bin_mode_e             w_mode;
  logic                  w_rise;
  logic                  w_close;
  logic                  w_accOver;
  logic                  w_binOver;
  logic [CNT_W-1:0]      w_accNext;

  logic [BIN_CNT_W-1:0]  r_binCnt;
  logic [CNT_W-1:0]      r_acc;
  logic                  r_accSat;
  logic [CNT_W-1:0]      r_binData;
  logic                  r_binSig;
  logic                  r_binSat;

  pulse_sync_edge u_photonSync (
    .clk     (clk),
    .rst     (rst_n),
    .i_async (photon),
    .o_rise  (w_rise)
  );

  assign w_mode    = en ? BIN_RUNNING : BIN_HELD;
  assign w_close   = (w_mode == BIN_RUNNING) && (r_binCnt == BIN_LAST);

  // An edge arriving in the close cycle is folded into the closing bin, so
  // the saturating sum below feeds both the accumulator and the output.
  assign w_accOver = satAddOver(32'(r_acc), 32'(w_rise), 32'(ACC_MAX));
  assign w_accNext = w_accOver ? ACC_MAX : r_acc + CNT_W'(w_rise);
  assign w_binOver = r_accSat | w_accOver;

  // Bin timer: free-runs 0..BIN_CYCLES-1 while enabled, parked at 0 otherwise
  // so that re-enabling always opens a fresh full-length bin.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_binCnt <= '0;
    end else if (w_mode == BIN_HELD || w_close) begin
      r_binCnt <= '0;
    end else begin
      r_binCnt <= r_binCnt + BIN_CNT_W'(1);
    end
  end

  // Photon accumulator with a sticky flag remembering that the running
  // count has clipped; both restart at every close and while disabled.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_acc    <= '0;
      r_accSat <= 1'b0;
    end else if (w_mode == BIN_HELD || w_close) begin
      r_acc    <= '0;
      r_accSat <= 1'b0;
    end else begin
      r_acc    <= w_accNext;
      r_accSat <= w_binOver;
    end
  end

  // Output register: publish the closing bin and pulse the strobe; count and
  // saturation flag hold between strobes and across disabled periods.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_binData <= '0;
      r_binSig  <= 1'b0;
      r_binSat  <= 1'b0;
    end else begin
      r_binSig <= w_close;
      if (w_close) begin
        r_binData <= w_accNext;
        r_binSat  <= w_binOver;
      end
    end
  end

  assign bin_data = r_binData;
  assign bin_sig  = r_binSig;
  assign bin_sat  = r_binSat;

`ifdef PHOTON_BINNER_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_ovfCnt;

  // Saturated-bin tally; deliberately untouched by en so it survives pauses.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ovfCnt <= '0;
    end else if (w_close && w_binOver) begin
      r_ovfCnt <= satInc(r_ovfCnt);
    end
  end

  assign ovf_cnt = r_ovfCnt;
`endif

endmodule

// File: tb/tb_photon_binner.sv
// Self-checking bench for photon_binner. Two instances run side by side:
// a 50-cycle binner for the timing scenarios and a 1200-cycle binner long
// enough to push more than 255 pulses into one bin. A pulse-level reference
// model predicts every output on every cycle.
module tb_photon_binner;

  localparam int BIN1 = 50;
  localparam int BIN2 = 1200;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic photon;
  logic en2;
  logic photon2;

  logic [7:0] data1;
  logic [7:0] data2;
  logic       sig1;
  logic       sig2;
  logic       sat1;
  logic       sat2;
`ifdef PHOTON_BINNER_OVF_CNT_EN
  logic [15:0] ovf1;
  logic [15:0] ovf2;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state, one slot per instance.
  int   mCnt  [2];
  int   mRun  [2];
  logic mPrev [2];
  logic mD1   [2];
  logic mD2   [2];
  logic mSig  [2];
  int   mData [2];
  logic mSat  [2];
  int   mOvf  [2];

  bit modelLive = 1'b0;
  bit dut2Done  = 1'b0;
  int satSeen2  = 0;

  photon_binner #(.BIN_CYCLES(BIN1), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst),
    .en       (en),
    .photon   (photon),
    .bin_data (data1),
    .bin_sig  (sig1),
    .bin_sat  (sat1)
`ifdef PHOTON_BINNER_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf1)
`endif
  );

  photon_binner #(.BIN_CYCLES(BIN2), .CNT_W(8)) dut2 (
    .clk      (clk),
    .rst_n    (rst),
    .en       (en2),
    .photon   (photon2),
    .bin_data (data2),
    .bin_sig  (sig2),
    .bin_sat  (sat2)
`ifdef PHOTON_BINNER_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock edge of the reference model. A photon rising edge seen at edge
  // k is credited at edge k+2 to whatever bin is open then (dropped if the
  // binner is disabled). A bin closes on its BIN-th consecutive enabled edge,
  // reporting min(count,255) and whether the true count passed 255.
  task automatic stepModel(input int id, input logic rstS, input logic enS,
                           input logic phS, input int binLen);
    logic rise;
    logic due;
    if (rstS) begin
      mCnt[id] = 0; mRun[id] = 0; mPrev[id] = 1'b0; mD1[id] = 1'b0; mD2[id] = 1'b0;
      mSig[id] = 1'b0; mData[id] = 0; mSat[id] = 1'b0; mOvf[id] = 0;
      return;
    end
    rise      = phS && !mPrev[id];
    mPrev[id] = phS;
    due       = mD2[id];
    mD2[id]   = mD1[id];
    mD1[id]   = rise;
    mSig[id]  = 1'b0;
    if (!enS) begin
      mRun[id] = 0;
      mCnt[id] = 0;
      return;
    end
    if (due) mCnt[id]++;
    mRun[id]++;
    if (mRun[id] == binLen) begin
      mRun[id]  = 0;
      mSig[id]  = 1'b1;
      mData[id] = (mCnt[id] > 255) ? 255 : mCnt[id];
      mSat[id]  = (mCnt[id] > 255);
      if (mSat[id] && mOvf[id] < 65535) mOvf[id]++;
      mCnt[id]  = 0;
    end
  endtask

  task automatic applyStimulus(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      photon = 1'b1;
      repeat (hi) @(negedge clk);
      photon = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic waitRun(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * BIN1 && !found; i++) begin
      @(negedge clk);
      if (mRun[0] == target && en) found = 1'b1;
    end
    checkOutput("waitRun", 32'(found), 32'd1);
  endtask

  task automatic waitStrobe(output logic [31:0] d);
    bit found;
    found = 1'b0;
    d = '0;
    for (int i = 0; i < 2 * BIN1 + 5 && !found; i++) begin
      @(negedge clk);
      if (sig1) begin
        found = 1'b1;
        d = 32'(data1);
      end
    end
    checkOutput("waitStrobe", 32'(found), 32'd1);
  endtask

  // Model advances on every rising edge from inputs stable since the negedge.
  initial begin
    forever begin
      @(posedge clk);
      stepModel(0, rst, en, photon, BIN1);
      stepModel(1, rst, en2, photon2, BIN2);
      if (rst) modelLive = 1'b1;
    end
  end

  // Compare every output against the model each cycle, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (modelLive) begin
        checkOutput("sig1", 32'(sig1), 32'(mSig[0]));
        checkOutput("data1", 32'(data1), 32'(mData[0]));
        checkOutput("sat1", 32'(sat1), 32'(mSat[0]));
        checkOutput("sig2", 32'(sig2), 32'(mSig[1]));
        checkOutput("data2", 32'(data2), 32'(mData[1]));
        checkOutput("sat2", 32'(sat2), 32'(mSat[1]));
`ifdef PHOTON_BINNER_OVF_CNT_EN
        checkOutput("ovf1", 32'(ovf1), 32'(mOvf[0]));
        checkOutput("ovf2", 32'(ovf2), 32'(mOvf[1]));
`endif
        if (sig2 === 1'b1 && sat2 === 1'b1) satSeen2++;
      end
    end
  end

  // Long-bin instance: a dense 2/2 pulse train packs about 300 pulses per
  // bin, then a quiet stretch returns it to unsaturated bins.
  initial begin
    en2 = 1'b0;
    photon2 = 1'b0;
    repeat (5) @(negedge clk);
    en2 = 1'b1;
    for (int c = 0; c < 4800; c += 4) begin
      photon2 = 1'b1;
      repeat (2) @(negedge clk);
      photon2 = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (1700) @(negedge clk);
    dut2Done = 1'b1;
  end

  initial begin
    int sc;
    int left;
    logic [31:0] d;
    rst = 1'b1;
    en = 1'b0;
    photon = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle enabled run: strobes at 50, 100, 150 cycles, all empty.
    en = 1'b1;
    sc = 0;
    repeat (150) begin
      @(negedge clk);
      if (sig1) sc++;
    end
    checkOutput("idleStrobes", 32'(sc), 32'd3);

    // Seven 3/3 pulses inside one bin, then an empty bin.
    waitRun(0);
    applyStimulus(3, 3, 7);
    waitStrobe(d);
    checkOutput("bin1Count", d, 32'd7);
    waitStrobe(d);
    checkOutput("bin2Count", d, 32'd0);

    // Pulse whose counted edge lands on the close cycle.
    waitRun(BIN1 - 3);
    photon = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("closeSig", 32'(sig1), 32'd1);
    checkOutput("closeEdgeCount", 32'(data1), 32'd1);
    photon = 1'b0;
    waitStrobe(d);
    checkOutput("afterCloseCount", d, 32'd0);

    // Random pulse widths with occasional enable toggles.
    left = 3;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if (left > 0) left--;
      if (left == 0) begin
        photon = ~photon;
        left = $urandom_range(2, 6);
      end
    end
    photon = 1'b0;
    en = 1'b1;
    repeat (4) @(negedge clk);

    // Drop en at counter 20, re-enable 10 cycles later.
    waitRun(0);
    applyStimulus(3, 3, 2);
    waitRun(20);
    en = 1'b0;
    sc = 0;
    repeat (10) begin
      @(negedge clk);
      if (sig1) sc++;
    end
    en = 1'b1;
    repeat (49) begin
      @(negedge clk);
      if (sig1) sc++;
    end
    checkOutput("partialDropped", 32'(sc), 32'd0);
    @(negedge clk);
    checkOutput("reenableStrobe", 32'(sig1), 32'd1);
    checkOutput("reenableData", 32'(data1), 32'd0);

    // Reset mid-bin holding 5 counts after a bin that reported 3.
    waitRun(0);
    applyStimulus(3, 3, 3);
    waitStrobe(d);
    checkOutput("preRstCount", d, 32'd3);
    applyStimulus(3, 3, 5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstData", 32'(data1), 32'd0);
    checkOutput("rstSig", 32'(sig1), 32'd0);
    checkOutput("rstSat", 32'(sat1), 32'd0);
`ifdef PHOTON_BINNER_OVF_CNT_EN
    checkOutput("rstOvf2", 32'(ovf2), 32'd0);
`endif
    rst = 1'b0;
    sc = 0;
    repeat (49) begin
      @(negedge clk);
      if (sig1) sc++;
    end
    checkOutput("postRstEarly", 32'(sc), 32'd0);
    @(negedge clk);
    checkOutput("postRstStrobe", 32'(sig1), 32'd1);
    checkOutput("postRstData", 32'(data1), 32'd0);

    for (int i = 0; i < 8000 && !dut2Done; i++) @(negedge clk);
    checkOutput("dut2Finished", 32'(dut2Done), 32'd1);
    checkOutput("dut2SatSeen", 32'(satSeen2 >= 1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
